// File: rtl/accel_pkg.sv
// Shared definitions for the ADXL345 polling sequencer: register map,
// configuration values, transaction list and FSM state type.
// Optional feature macro: ADXL_DEVID_CHECK_EN (prepends a DEVID read to init).
package accel_pkg;

    localparam logic [7:0] REG_DEVID       = 8'h00;
    localparam logic [7:0] REG_BW_RATE     = 8'h2C;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_DATAX0      = 8'h32;
    localparam logic [7:0] REG_DATAX1      = 8'h33;

    localparam logic [7:0] VAL_DATA_FORMAT = 8'h08;  // full resolution, +/-2g
    localparam logic [7:0] VAL_BW_RATE     = 8'h0A;  // 100 Hz output rate
    localparam logic [7:0] VAL_POWER_CTL   = 8'h08;  // measurement mode
    localparam logic [7:0] DEVID_EXPECTED  = 8'hE5;

`ifdef ADXL_DEVID_CHECK_EN
    localparam logic [2:0] IDX_FIRST_WRITE = 3'd1;
`else
    localparam logic [2:0] IDX_FIRST_WRITE = 3'd0;
`endif
    localparam logic [2:0] IDX_LAST_INIT = IDX_FIRST_WRITE + 3'd2;
    localparam logic [2:0] IDX_X0        = IDX_LAST_INIT + 3'd1;
    localparam logic [2:0] IDX_X1        = IDX_X0 + 3'd1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        NEXT,
        WAIT_TICK,
        PUBLISH,
        ERROR
    } seq_state_e;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic       rw;
        logic [7:0] data;
    } xfer_t;

    // Transaction list: optional ID read, three config writes, two data reads.
    function automatic xfer_t list_entry(input logic [2:0] idx);
        xfer_t e;
        e = '{REG_DEVID, 1'b1, 8'h00};
        if (idx == IDX_FIRST_WRITE)              e = '{REG_DATA_FORMAT, 1'b0, VAL_DATA_FORMAT};
        else if (idx == IDX_FIRST_WRITE + 3'd1)  e = '{REG_BW_RATE, 1'b0, VAL_BW_RATE};
        else if (idx == IDX_LAST_INIT)           e = '{REG_POWER_CTL, 1'b0, VAL_POWER_CTL};
        else if (idx == IDX_X0)                  e = '{REG_DATAX0, 1'b1, 8'h00};
        else if (idx == IDX_X1)                  e = '{REG_DATAX1, 1'b1, 8'h00};
        return e;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate tick: one-cycle pulse every PERIOD cycles while enabled.
// The first tick fires on the first enabled cycle, so polling begins right
// after configuration rather than one full period later.
module sample_tick_gen #(
    parameter int PERIOD = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt;

    // Down-counter reloaded on terminal count; tick registered at terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (cnt == '0) begin
                    tick <= 1'b1;
                    cnt  <= CW'(PERIOD - 1);
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adxl345_poll_seq.sv
// ADXL345 configuration and X-axis polling sequencer driving i2c_controller.
// Optional feature macro: ADXL_DEVID_CHECK_EN (verify DEVID = 0xE5 before init).
//
// state     | meaning
// IDLE      | after reset, waiting for the controller to become ready
// ISSUE     | present current list entry and pulse start once ready
// WAIT_DONE | transaction in flight, timeout counting down
// NEXT      | advance list; sample is registered here when the X1 read ends
// WAIT_TICK | configured, waiting for a pending sample tick
// PUBLISH   | cycle in which sample_x / sample_valid are presented
// ERROR     | timeout or bad ID, terminal until reset
module adxl345_poll_seq
    import accel_pkg::*;
#(
    parameter int         SYS_CLK_SPEED  = 50000000,
    parameter int         SAMPLE_RATE_HZ = 100,
    parameter logic [6:0] DEV_ADDR_P     = 7'h1D,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic        i2c_comms_finished,
    input  logic [7:0]  READ_DATA,
    output logic        start_i2c_comms,
    output logic [6:0]  DEV_ADDR,
    output logic [7:0]  REG_ADDR,
    output logic        R_W,
    output logic [7:0]  WRITE_DATA,
    output logic [15:0] sample_x,
    output logic        sample_valid,
    output logic        init_done,
    output logic        error,
    output logic [7:0]  overrun_cnt
);
    localparam int TICK_PERIOD = SYS_CLK_SPEED / SAMPLE_RATE_HZ;
    localparam int TW          = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_e    state;
    logic [2:0]    idx;
    logic [7:0]    lo_byte;
    logic [7:0]    hi_byte;
    logic [TW-1:0] tmo_cnt;
    logic          tick;
    logic          pending;
    logic          pending_clr;
    xfer_t         cur;

    assign DEV_ADDR    = DEV_ADDR_P;
    assign cur         = list_entry(idx);
    assign pending_clr = (state == WAIT_TICK) && pending;

    sample_tick_gen #(.PERIOD(TICK_PERIOD)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (init_done),
        .tick (tick)
    );

    // One-deep pending tick; a tick landing on the clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 1'b0;
            overrun_cnt <= 8'h00;
        end else if (tick) begin
            if (pending && !pending_clr && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'h01;
            pending <= 1'b1;
        end else if (pending_clr) begin
            pending <= 1'b0;
        end
    end

    // Sequencer FSM with registered bus-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= 3'd0;
            start_i2c_comms <= 1'b0;
            REG_ADDR        <= 8'h00;
            R_W             <= 1'b0;
            WRITE_DATA      <= 8'h00;
            lo_byte         <= 8'h00;
            hi_byte         <= 8'h00;
            tmo_cnt         <= '0;
            sample_x        <= 16'h0000;
            sample_valid    <= 1'b0;
            init_done       <= 1'b0;
            error           <= 1'b0;
        end else begin
            start_i2c_comms <= 1'b0;
            sample_valid    <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready) begin
                        idx   <= 3'd0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ready) begin
                        REG_ADDR        <= cur.reg_addr;
                        R_W             <= cur.rw;
                        WRITE_DATA      <= cur.data;
                        start_i2c_comms <= 1'b1;
                        tmo_cnt         <= TW'(TIMEOUT_CYCLES);
                        state           <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i2c_comms_finished) begin
                        if (idx == IDX_X0) lo_byte <= READ_DATA;
                        if (idx == IDX_X1) hi_byte <= READ_DATA;
                        state <= NEXT;
`ifdef ADXL_DEVID_CHECK_EN
                        if (idx == 3'd0 && READ_DATA != DEVID_EXPECTED) begin
                            error <= 1'b1;
                            state <= ERROR;
                        end
`endif
                    end else if (tmo_cnt == '0) begin
                        error <= 1'b1;
                        state <= ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                NEXT: begin
                    if (idx == IDX_LAST_INIT) begin
                        idx       <= IDX_X0;
                        init_done <= 1'b1;
                        state     <= WAIT_TICK;
                    end else if (idx == IDX_X1) begin
                        // Registered here so the sample lands two cycles after finished.
                        sample_x     <= {hi_byte, lo_byte};
                        sample_valid <= 1'b1;
                        state        <= PUBLISH;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= ISSUE;
                    end
                end
                PUBLISH: begin
                    state <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (pending) begin
                        idx   <= IDX_X0;
                        state <= ISSUE;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
